alu_cmd_initiator: RTL and testbench

Command-side initiator for the 8-bit ALU: accepts operation requests over a valid/ready port, buffers them in a small FIFO, drives operand and control lines into the ALU, waits a fixed ALU latency, captures the result, generates status flags and returns a tagged response over a second valid/ready port. Sits between the datapath sequencer (upstream) and the ALU (downstream), one operation in flight at a time, in order.

---
 rtl/alu_cmd_initiator.sv | 139 +++++++++++++
 tb/tb_alu_cmd_initiator.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_initiator.sv
// Command-side initiator for the 8-bit ALU: queues requests, issues them one at a
// time to the ALU, waits the fixed ALU latency and returns tagged, flagged responses.
module alu_cmd_initiator #(
  parameter int DATA_W     = 8,
  parameter int CTRL_W     = 3,
  parameter int TAG_W      = 4,
  parameter int ALU_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              req_valid_in,
  output logic              req_ready_out,
  input  logic [DATA_W-1:0] req_a_in,
  input  logic [DATA_W-1:0] req_b_in,
  input  logic [CTRL_W-1:0] req_op_in,
  input  logic [TAG_W-1:0]  req_tag_in,
  output logic [DATA_W-1:0] alu_a_out,
  output logic [DATA_W-1:0] alu_b_out,
  output logic [CTRL_W-1:0] alu_ctrl_out,
  input  logic [DATA_W-1:0] alu_result_in,
  output logic              rsp_valid_out,
  input  logic              rsp_ready_in,
  output logic [DATA_W-1:0] rsp_result_out,
  output logic [TAG_W-1:0]  rsp_tag_out,
  output logic [3:0]        rsp_flags_out,
  output logic              busy_out,
  output logic [1:0]        dbg_state_out
);

  // Both ports use valid/ready: a transfer happens at a rising edge where valid and
  // ready are both high; a raised valid and its payload hold until that edge.

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 2 * DATA_W + CTRL_W + TAG_W;
  localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state;
  logic [3:0]         cnt;
  logic [ENT_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [DATA_W-1:0]  head_a;
  logic [DATA_W-1:0]  head_b;
  logic [CTRL_W-1:0]  head_op;
  logic [TAG_W-1:0]   head_tag;
  logic               head_legal;
  logic               push;
  logic               pop;

  assign {head_a, head_b, head_op, head_tag} = mem[rd_ptr];
  assign head_legal    = (head_op != '0) && (head_op != '1);
  assign req_ready_out = (count != CNT_W'(FIFO_DEPTH));
  assign push          = req_valid_in && req_ready_out;
  // The next op is taken from IDLE, or on the very edge the current response is accepted.
  assign pop           = (count != '0) &&
                         ((state == S_IDLE) || ((state == S_RESP) && rsp_ready_in));
  assign busy_out      = (state != S_IDLE) || (count != '0);
  assign dbg_state_out = state;

  function automatic logic [3:0] legal_flags(input logic [DATA_W-1:0] r);
    return {1'b0, ^r, r[DATA_W-1], (r == '0)};
  endfunction

  // Storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= {req_a_in, req_b_in, req_op_in, req_tag_in};
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= S_IDLE;
      cnt            <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      alu_a_out      <= '0;
      alu_b_out      <= '0;
      alu_ctrl_out   <= '0;
      rsp_valid_out  <= 1'b0;
      rsp_result_out <= '0;
      rsp_tag_out    <= '0;
      rsp_flags_out  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);

      case (state)
        S_IDLE: ;
        S_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_result_out <= alu_result_in;
            rsp_flags_out  <= legal_flags(alu_result_in);
            rsp_valid_out  <= 1'b1;
            state          <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready_in) begin
            rsp_valid_out <= 1'b0;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Issue overrides the case above so a popped op starts on the same edge.
      if (pop) begin
        rsp_tag_out <= head_tag;
        if (head_legal) begin
          alu_a_out     <= head_a;
          alu_b_out     <= head_b;
          alu_ctrl_out  <= head_op;
          cnt           <= LAT_LOAD;
          rsp_valid_out <= 1'b0;
          state         <= S_WAIT;
        end else begin
          rsp_result_out <= '0;
          rsp_flags_out  <= 4'b1000;
          rsp_valid_out  <= 1'b1;
          state          <= S_RESP;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_initiator.sv
// Bench for alu_cmd_initiator: one instance with ALU latency 1 and one with latency 3,
// each fed by a behavioural ALU that returns garbage until operands are old enough.
module tb_alu_cmd_initiator;

  localparam int LAT1 = 1;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       sel;
  logic       req_valid;
  logic [7:0] req_a, req_b;
  logic [2:0] req_op;
  logic [3:0] req_tag;
  logic       rsp_ready;

  logic       r1_ready, v1, busy1, r3_ready, v3, busy3;
  logic [7:0] a1_a, a1_b, res1, alu1_res, a3_a, a3_b, res3, alu3_res;
  logic [2:0] a1_ctrl, a3_ctrl;
  logic [3:0] tag1, fl1, tag3, fl3;
  logic [1:0] st1, st3;
  logic       rdy1, rdy3;

  assign rdy1 = sel ? 1'b1 : rsp_ready;
  assign rdy3 = sel ? rsp_ready : 1'b1;

  alu_cmd_initiator #(.ALU_LAT(LAT1)) dut1 (
    .clk_in(clk), .rst_n_in(rst_n), .req_valid_in(req_valid & ~sel), .req_ready_out(r1_ready),
    .req_a_in(req_a), .req_b_in(req_b), .req_op_in(req_op), .req_tag_in(req_tag),
    .alu_a_out(a1_a), .alu_b_out(a1_b), .alu_ctrl_out(a1_ctrl), .alu_result_in(alu1_res),
    .rsp_valid_out(v1), .rsp_ready_in(rdy1), .rsp_result_out(res1), .rsp_tag_out(tag1),
    .rsp_flags_out(fl1), .busy_out(busy1), .dbg_state_out(st1));

  alu_cmd_initiator #(.ALU_LAT(LAT3)) dut3 (
    .clk_in(clk), .rst_n_in(rst_n), .req_valid_in(req_valid & sel), .req_ready_out(r3_ready),
    .req_a_in(req_a), .req_b_in(req_b), .req_op_in(req_op), .req_tag_in(req_tag),
    .alu_a_out(a3_a), .alu_b_out(a3_b), .alu_ctrl_out(a3_ctrl), .alu_result_in(alu3_res),
    .rsp_valid_out(v3), .rsp_ready_in(rdy3), .rsp_result_out(res3), .rsp_tag_out(tag3),
    .rsp_flags_out(fl3), .busy_out(busy3), .dbg_state_out(st3));

  logic       cur_ready, cur_valid, cur_busy;
  logic [7:0] cur_res;
  logic [3:0] cur_tag, cur_fl;
  logic [2:0] cur_ctrl;
  assign cur_ready = sel ? r3_ready : r1_ready;
  assign cur_valid = sel ? v3 : v1;
  assign cur_busy  = sel ? busy3 : busy1;
  assign cur_res   = sel ? res3 : res1;
  assign cur_tag   = sel ? tag3 : tag1;
  assign cur_fl    = sel ? fl3 : fl1;
  assign cur_ctrl  = sel ? a3_ctrl : a1_ctrl;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int age1 = 0, age3 = 0;
  int rsp_cnt1 = 0, rsp_cnt3 = 0;
  logic [18:0] prev1 = '0, prev3 = '0;
  logic [15:0] exp_q1[$];
  logic [15:0] exp_q3[$];
  int iss3_q[$];

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      3'd1: return a + b;
      3'd2: return a - b;
      3'd3: return a & b;
      3'd4: return a | b;
      3'd5: return a ^ b;
      3'd6: return {a[6:0], 1'b0};
      default: return 8'hA5;
    endcase
  endfunction

  // Expected response word {tag, flags, result}.
  function automatic logic [15:0] exp_of(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op, input logic [3:0] tag);
    logic [7:0] r;
    if (op == 3'd0 || op == 3'd7) return {tag, 4'b1000, 8'h00};
    r = alu_f(a, b, op);
    return {tag, 1'b0, ^r, r[7], (r == 8'h00), r};
  endfunction

  assign alu1_res = (age1 >= LAT1 - 1) ? alu_f(a1_a, a1_b, a1_ctrl) : ~alu_f(a1_a, a1_b, a1_ctrl);
  assign alu3_res = (age3 >= LAT3 - 1) ? alu_f(a3_a, a3_b, a3_ctrl) : ~alu_f(a3_a, a3_b, a3_ctrl);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Operand age tracking for the ALU models, plus issue timestamps of dut3.
  always @(negedge clk) begin
    if ({a1_a, a1_b, a1_ctrl} != prev1) age1 = 0;
    else if (age1 < 1000) age1++;
    prev1 = {a1_a, a1_b, a1_ctrl};
    if ({a3_a, a3_b, a3_ctrl} != prev3) begin
      age3 = 0;
      iss3_q.push_back(cyc);
    end else if (age3 < 1000) age3++;
    prev3 = {a3_a, a3_b, a3_ctrl};
  end

  // Scoreboards: compare on every response handshake.
  always @(negedge clk) begin
    if (v1 && rdy1) begin
      rsp_cnt1++;
      if (exp_q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb1_extra actual=%0h required=none", {tag1, fl1, res1});
      end else chk("sb1", {16'h0, tag1, fl1, res1}, {16'h0, exp_q1.pop_front()});
    end
    if (v3 && rdy3) begin
      rsp_cnt3++;
      if (exp_q3.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb3_extra actual=%0h required=none", {tag3, fl3, res3});
      end else chk("sb3", {16'h0, tag3, fl3, res3}, {16'h0, exp_q3.pop_front()});
    end
  end

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic [3:0] tag, input int max_cyc, output bit ok);
    @(posedge clk);
    #1;
    req_a = a; req_b = b; req_op = op; req_tag = tag; req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      if (cur_ready) ok = 1'b1;
      @(posedge clk);
    end
    if (ok) begin
      if (sel) exp_q3.push_back(exp_of(a, b, op, tag));
      else     exp_q1.push_back(exp_of(a, b, op, tag));
    end
    #1 req_valid = 1'b0;
  endtask

  task automatic ack();
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic wait_rsp(input int max_cyc, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      @(negedge clk);
      if (cur_valid) got = 1'b1;
    end
  endtask

  task automatic wait_drain(input int max_cyc, output bit done);
    done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk);
      if (!cur_busy && (sel ? exp_q3.size() : exp_q1.size()) == 0) done = 1'b1;
    end
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic [2:0] op;
    logic [3:0] tag;
    logic [7:0] res;
    logic [3:0] flg;
  } vec_t;
  vec_t vecs[11];

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok, got, done;
    logic [2:0] last_op;
    int base;

    vecs[0]  = '{8'h12, 8'h34, 3'd1, 4'd5,  8'h46, 4'b0100};
    vecs[1]  = '{8'h80, 8'h80, 3'd1, 4'd1,  8'h00, 4'b0001};
    vecs[2]  = '{8'h00, 8'h80, 3'd4, 4'd7,  8'h80, 4'b0110};
    vecs[3]  = '{8'h05, 8'h06, 3'd2, 4'd2,  8'hFF, 4'b0010};
    vecs[4]  = '{8'hF0, 8'h3C, 3'd3, 4'd3,  8'h30, 4'b0000};
    vecs[5]  = '{8'h0F, 8'hFF, 3'd5, 4'd4,  8'hF0, 4'b0010};
    vecs[6]  = '{8'h41, 8'h00, 3'd6, 4'd6,  8'h82, 4'b0010};
    vecs[7]  = '{8'h11, 8'h22, 3'd7, 4'd9,  8'h00, 4'b1000};
    vecs[8]  = '{8'h33, 8'h44, 3'd0, 4'd10, 8'h00, 4'b1000};
    vecs[9]  = '{8'h7F, 8'h01, 3'd1, 4'd11, 8'h80, 4'b0110};
    vecs[10] = '{8'h01, 8'h00, 3'd4, 4'd12, 8'h01, 4'b0100};

    sel = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; req_tag = '0;
    rsp_ready = 1'b0; last_op = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready1", r1_ready, 1); chk("rst_busy1", busy1, 0); chk("rst_valid1", v1, 0);
    chk("rst_ctrl1", a1_ctrl, 0);   chk("rst_ready3", r3_ready, 1); chk("rst_valid3", v3, 0);
    rst_n = 1'b1;

    // Single op latency, ALU_LAT=1
    push(8'h12, 8'h34, 3'd1, 4'd5, 8, ok); chk("single_push", ok, 1);
    @(negedge clk); chk("single_lat_e0", v1, 0);
    @(negedge clk); chk("single_lat_e1", v1, 0);
    chk("single_issue_a", a1_a, 8'h12); chk("single_issue_b", a1_b, 8'h34);
    chk("single_issue_ctrl", a1_ctrl, 1);
    @(negedge clk); chk("single_lat_e2", v1, 1);
    chk("single_res", res1, 8'h46); chk("single_tag", tag1, 5); chk("single_flags", fl1, 4'b0100);
    @(negedge clk); chk("single_hold", {v1, res1}, {1'b1, 8'h46});
    ack();
    last_op = 3'd1;

    // Table vectors
    for (int i = 0; i < 11; i++) begin
      push(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].tag, 8, ok);
      chk($sformatf("vec%0d_push", i), ok, 1);
      wait_rsp(10, got);
      chk($sformatf("vec%0d_rsp_seen", i), got, 1);
      chk($sformatf("vec%0d_res", i), cur_res, vecs[i].res);
      chk($sformatf("vec%0d_tag", i), cur_tag, vecs[i].tag);
      chk($sformatf("vec%0d_flags", i), cur_fl, vecs[i].flg);
      if (vecs[i].op == 3'd0 || vecs[i].op == 3'd7) chk($sformatf("vec%0d_ctrl_held", i), cur_ctrl, last_op);
      else last_op = vecs[i].op;
      ack();
    end

    // Backpressure: one in flight plus four queued, sixth blocked
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      push(8'(k * 16 + 3), 8'(k), 3'd1, 4'(k + 1), 6, ok);
      chk($sformatf("full_acc%0d", k), ok, 1);
    end
    @(negedge clk); chk("full_ready_low", cur_ready, 0); chk("full_busy", cur_busy, 1);
    push(8'h53, 8'h05, 3'd1, 4'd6, 4, ok); chk("full_block", ok, 0);
    base = rsp_cnt1;
    rsp_ready = 1'b1;
    push(8'h53, 8'h05, 3'd1, 4'd6, 20, ok); chk("full_late_acc", ok, 1);
    wait_drain(60, done); chk("full_drain", done, 1);
    chk("full_rsp_count", rsp_cnt1 - base, 6);
    rsp_ready = 1'b0;

    // Streaming on ALU_LAT=3: issue period is ALU_LAT+1 since the response holds one edge
    sel = 1'b1; rsp_ready = 1'b1;
    iss3_q.delete();
    for (int k = 0; k < 5; k++) begin
      push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'(k + 1), 4'(k), 20, ok);
      chk($sformatf("stream_acc%0d", k), ok, 1);
    end
    wait_drain(60, done); chk("stream_drain", done, 1);
    chk("stream_issues", iss3_q.size(), 5);
    for (int i = 1; i < iss3_q.size(); i++)
      chk($sformatf("stream_gap%0d", i), iss3_q[i] - iss3_q[i - 1], LAT3 + 1);

    // Illegal opcode on ALU_LAT=3: response one edge after pop, ALU untouched
    rsp_ready = 1'b0;
    push(8'h11, 8'h22, 3'd7, 4'd9, 8, ok); chk("ill_push", ok, 1);
    @(negedge clk); chk("ill_lat_e0", v3, 0);
    @(negedge clk); chk("ill_lat_e1", v3, 1);
    chk("ill_res", res3, 0); chk("ill_flags", fl3, 4'b1000); chk("ill_tag", tag3, 9);
    chk("ill_ctrl_held", a3_ctrl, 5);
    ack();

    // Reset mid-WAIT with three entries queued
    for (int k = 0; k < 5; k++) begin
      push(8'(k + 1), 8'(k + 2), 3'd1, 4'(k + 1), 6, ok);
      chk($sformatf("rstq_acc%0d", k), ok, 1);
    end
    ack();
    @(negedge clk); chk("rstq_state_wait", st3, 1); chk("rstq_ready", r3_ready, 1);
    rst_n = 1'b0;
    exp_q3.delete();
    #1;
    chk("rstq_alu", {a3_a, a3_b, a3_ctrl}, 0); chk("rstq_valid", v3, 0);
    chk("rstq_rsp", {tag3, fl3, res3}, 0); chk("rstq_ready_hi", r3_ready, 1);
    chk("rstq_busy", busy3, 0); chk("rstq_state", st3, 0);
    @(negedge clk); rst_n = 1'b1;
    base = rsp_cnt3;
    rsp_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("rstq_no_rsp", rsp_cnt3 - base, 0); chk("rstq_busy_after", busy3, 0);

    chk("end_q1_empty", exp_q1.size(), 0);
    chk("end_q3_empty", exp_q3.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
